axi_slave_mem: RTL and testbench
================================

# axi_slave_mem

AXI4 memory slave that answers the DMA master in `axi_top` on the far end of its AXI bus. It has independent write (AW/W/B) and read (AR/R) engines sharing one word-organised memory array. It supports FIXED, INCR and WRAP bursts of up to 256 beats with byte strobes. It is the responder the DMA testbench connects to in place of real memory.

## Interface
- AXI_ID_WD, 2, ID width
- AXI_DATA_WD, 32, data width
- AXI_ADDR_WD, 16, byte-address width
- AXI_STRB_WD, 4, strobe width (AXI_DATA_WD/8)
- MEM_AW, 10, word-address bits of the array (2^MEM_AW words)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - AXI_ACLK  in  1  clock
  - AXI_ARESETN  in  1  reset
- AW channel:
  - AWID/AWADDR/AWLEN[7:0]/AWSIZE[2:0]/AWBURST[1:0]  in  widths per params  write address
  - AWVALID in 1, AWREADY out 1
- W channel:
  - WDATA  in  AXI_DATA_WD
  - WSTRB  in  AXI_STRB_WD
  - WLAST  in  1
  - WVALID in 1, WREADY out 1
- B channel:
  - BID  out  AXI_ID_WD
  - BRESP  out  2
  - BVALID out 1, BREADY in 1
- AR channel:
  - ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  as AW
  - ARVALID in 1, ARREADY out 1
- R channel:
  - RID  out  AXI_ID_WD
  - RDATA  out  AXI_DATA_WD
  - RRESP  out  2
  - RLAST  out  1
  - RVALID out 1, RREADY in 1

## Operation
- Write FSM states W_IDLE, W_DATA, W_RESP.
  - W_IDLE: AWREADY=1. On an AW handshake, latch id/addr/len/size/burst, clear the beat counter, go to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes the byte lanes enabled by WSTRB to mem[addr[MEM_AW+1:2]], then advances addr and the counter. The beat with counter==len ends the burst and the FSM goes to W_RESP, whether or not WLAST is set.
  - W_RESP: BVALID=1 with BID=latched id. Hold until BREADY, then return to W_IDLE.
- Read FSM states R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On an AR handshake, latch the fields and register RDATA=mem[araddr word], go to R_DATA.
  - R_DATA: RVALID=1; RLAST=(counter==len). On an R handshake that is not last, load the next beat's word into RDATA in the same cycle. On the last handshake, return to R_IDLE.
- Address update, with bytes = 1<<size:
  - FIXED: unchanged.
  - INCR: addr+bytes, truncated to AXI_ADDR_WD.
  - WRAP: container = (len+1)*bytes; the low bits inside the container increment and wrap; the upper bits are held. len must be 1, 3, 7 or 15 (not checked).
  - Burst type 2'b11 is treated as INCR.
- Address bits above MEM_AW+2 are ignored; the array aliases modulo its size.
- Reads return the full word for narrow sizes.
- Memory contents are not reset.
- The engines are independent. A write and a read to the same word in the same cycle: the read gets the old data.

## Timing
- Reset values:
  - AWREADY=1, ARREADY=1.
  - WREADY=0, BVALID=0, RVALID=0, RLAST=0.
  - BRESP=RRESP=0, BID=RID=0, RDATA=0.
  - FSMs in W_IDLE and R_IDLE.
- Write: WREADY rises 1 cycle after the AW handshake. Full-rate beats are allowed. BVALID rises 1 cycle after the last W handshake.
- Read: RVALID rises 1 cycle after the AR handshake. Back-to-back beats run at 1 per cycle while RREADY=1.
- RDATA, RID, RRESP and RLAST are stable while RVALID=1 and RREADY=0.
- AWREADY=0 outside W_IDLE; ARREADY=0 outside R_IDLE. There is one outstanding transaction per direction.
- Reset asserted mid-burst: all FSMs go to idle immediately, valids drop, and the partial write already performed is kept.

## Configuration
- AXI_SLV_ERR_CHK_EN defined: a burst gets SLVERR if any of these hold:
  - an INCR burst crosses a 4 KB boundary;
  - size > log2(AXI_STRB_WD);
  - on a write, WLAST differs from (counter==len) on any beat.
- SLVERR handling:
  - A write with SLVERR suppresses all array writes for the beats after detection; a size or 4 KB error suppresses the whole burst.
  - On reads, every beat returns RRESP=SLVERR and RDATA=0.
- Undefined: BRESP and RRESP are always OKAY, and addresses simply alias.

## Test plan
- Single-beat write then read. AW addr=0x0010, len=0, size=2, WDATA=0xA5A5_1234, WSTRB=0xF, then AR to the same address. Expect BRESP=OKAY, RDATA=0xA5A5_1234, RLAST=1 on the first beat.
- INCR write burst. Addr 0x00FC, len=15, data=i, full-rate. Read it back with RREADY toggling every cycle. Expect 16 beats with values 0..15, RLAST only on beat 15, and data held during stalls.
- WRAP burst. Addr 0x0108, len=3, size=2. Expect the word sequence 0x108, 0x10C, 0x100, 0x104.
- Strobes. Write 0xFFFF_FFFF, then write 0x1122_3344 with WSTRB=0x5, then read. Expect 0xFF22_FF44.
- With AXI_SLV_ERR_CHK_EN: INCR addr=0x0FF8, len=3, size=2. Expect BRESP=SLVERR and memory unchanged. A read of the same burst returns 4 beats with RRESP=SLVERR.
- Reset mid-burst. Drop AXI_ARESETN on beat 2 of an 8-beat read. Expect RVALID=0 at once, ARREADY=1. A new AR after reset completes normally.

Source files
------------

// File: rtl/axi_slave_mem_if.sv
// AXI4 write (AW/W/B) and read (AR/R) channel bundle between a master and axi_slave_mem.
interface axi_slave_mem_if #(
    parameter int AXI_ID_WD   = 2,
    parameter int AXI_DATA_WD = 32,
    parameter int AXI_ADDR_WD = 16,
    parameter int AXI_STRB_WD = 4
);
    logic [AXI_ID_WD-1:0]   AWID;
    logic [AXI_ADDR_WD-1:0] AWADDR;
    logic [7:0]             AWLEN;
    logic [2:0]             AWSIZE;
    logic [1:0]             AWBURST;
    logic                   AWVALID;
    logic                   AWREADY;

    logic [AXI_DATA_WD-1:0] WDATA;
    logic [AXI_STRB_WD-1:0] WSTRB;
    logic                   WLAST;
    logic                   WVALID;
    logic                   WREADY;

    logic [AXI_ID_WD-1:0]   BID;
    logic [1:0]             BRESP;
    logic                   BVALID;
    logic                   BREADY;

    logic [AXI_ID_WD-1:0]   ARID;
    logic [AXI_ADDR_WD-1:0] ARADDR;
    logic [7:0]             ARLEN;
    logic [2:0]             ARSIZE;
    logic [1:0]             ARBURST;
    logic                   ARVALID;
    logic                   ARREADY;

    logic [AXI_ID_WD-1:0]   RID;
    logic [AXI_DATA_WD-1:0] RDATA;
    logic [1:0]             RRESP;
    logic                   RLAST;
    logic                   RVALID;
    logic                   RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
        output WDATA, WSTRB, WLAST, WVALID, input WREADY,
        input BID, BRESP, BVALID, output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
        input RID, RDATA, RRESP, RLAST, RVALID, output RREADY
    );

    modport slave (
        input AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
        input WDATA, WSTRB, WLAST, WVALID, output WREADY,
        output BID, BRESP, BVALID, input BREADY,
        input ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
    );
endinterface

// File: rtl/axi_slave_mem.sv
// AXI4 memory slave: independent write and read engines over one word array.
// Define AXI_SLV_ERR_CHK_EN to return SLVERR on 4 KB crossings, oversize beats and WLAST mismatches.
//   state  | meaning
//   W_IDLE | waiting for AW
//   W_DATA | accepting W beats
//   W_RESP | presenting B
//   R_IDLE | waiting for AR
//   R_DATA | presenting R beats
module axi_slave_mem #(
    parameter int AXI_ID_WD   = 2,
    parameter int AXI_DATA_WD = 32,
    parameter int AXI_ADDR_WD = 16,
    parameter int AXI_STRB_WD = 4,
    parameter int MEM_AW      = 10
) (
    input logic            AXI_ACLK,
    input logic            AXI_ARESETN,
    axi_slave_mem_if.slave bus
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [AXI_DATA_WD-1:0] mem [2**MEM_AW];

    w_state_t               w_state, w_next;
    logic [AXI_ID_WD-1:0]   w_id;
    logic [AXI_ADDR_WD-1:0] w_addr;
    logic [7:0]             w_len, w_cnt;
    logic [2:0]             w_size;
    logic [1:0]             w_burst;
    logic                   w_last_beat, aw_hs, w_hs, w_we;

    r_state_t               r_state, r_next;
    logic [AXI_ID_WD-1:0]   r_id;
    logic [AXI_ADDR_WD-1:0] r_addr, r_addr_nxt;
    logic [7:0]             r_len, r_cnt;
    logic [2:0]             r_size;
    logic [1:0]             r_burst;
    logic [AXI_DATA_WD-1:0] rdata;
    logic                   r_last_beat, ar_hs, r_adv;

    // WRAP keeps the bits above the (len+1)*bytes container and wraps the bits inside it.
    function automatic logic [AXI_ADDR_WD-1:0] next_addr(
        input logic [AXI_ADDR_WD-1:0] addr,
        input logic [7:0]             len,
        input logic [2:0]             size,
        input logic [1:0]             burst
    );
        logic [AXI_ADDR_WD-1:0] inc, mask;
        inc  = addr + (AXI_ADDR_WD'(1) << size);
        mask = AXI_ADDR_WD'((({24'd0, len} + 32'd1) << size) - 32'd1);
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~mask) | (inc & mask);
            default: next_addr = inc;
        endcase
    endfunction

`ifdef AXI_SLV_ERR_CHK_EN
    logic w_err, r_err;

    function automatic logic burst_err(
        input logic [AXI_ADDR_WD-1:0] addr,
        input logic [7:0]             len,
        input logic [2:0]             size,
        input logic [1:0]             burst
    );
        logic [31:0] total;
        total = ({24'd0, len} + 32'd1) << size;
        burst_err = (size > 3'($clog2(AXI_STRB_WD))) ||
                    ((burst == 2'b01 || burst == 2'b11) &&
                     (32'(addr[11:0]) + total > 32'd4096));
    endfunction
`endif

    assign w_last_beat = (w_cnt == w_len);
    assign aw_hs       = (w_state == W_IDLE) && bus.AWVALID;
    assign w_hs        = (w_state == W_DATA) && bus.WVALID;

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) w_state <= W_IDLE;
        else              w_state <= w_next;
    end

    always_comb begin
        w_next      = w_state;
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b0;
        bus.BVALID  = 1'b0;
        case (w_state)
            W_IDLE: begin
                bus.AWREADY = 1'b1;
                if (bus.AWVALID) w_next = W_DATA;
            end
            W_DATA: begin
                bus.WREADY = 1'b1;
                if (bus.WVALID && w_last_beat) w_next = W_RESP;
            end
            W_RESP: begin
                bus.BVALID = 1'b1;
                if (bus.BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
`ifdef AXI_SLV_ERR_CHK_EN
            w_err   <= 1'b0;
`endif
        end else if (aw_hs) begin
            w_id    <= bus.AWID;
            w_addr  <= bus.AWADDR;
            w_len   <= bus.AWLEN;
            w_size  <= bus.AWSIZE;
            w_burst <= bus.AWBURST;
            w_cnt   <= '0;
`ifdef AXI_SLV_ERR_CHK_EN
            w_err   <= burst_err(bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST);
`endif
        end else if (w_hs) begin
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            w_cnt  <= w_cnt + 8'd1;
`ifdef AXI_SLV_ERR_CHK_EN
            if (bus.WLAST != w_last_beat) w_err <= 1'b1;
`endif
        end
    end

`ifdef AXI_SLV_ERR_CHK_EN
    // A WLAST mismatch blocks its own beat as well as the rest of the burst.
    assign w_we = w_hs && !w_err && (bus.WLAST == w_last_beat);
`else
    assign w_we = w_hs;
`endif

    always_ff @(posedge AXI_ACLK) begin
        if (w_we) begin
            for (int b = 0; b < AXI_STRB_WD; b++) begin
                if (bus.WSTRB[b]) mem[w_addr[MEM_AW+1:2]][b*8 +: 8] <= bus.WDATA[b*8 +: 8];
            end
        end
    end

    assign bus.BID = w_id;

    assign r_last_beat = (r_cnt == r_len);
    assign ar_hs       = (r_state == R_IDLE) && bus.ARVALID;
    assign r_adv       = (r_state == R_DATA) && bus.RREADY && !r_last_beat;
    assign r_addr_nxt  = next_addr(r_addr, r_len, r_size, r_burst);

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) r_state <= R_IDLE;
        else              r_state <= r_next;
    end

    always_comb begin
        r_next      = r_state;
        bus.ARREADY = 1'b0;
        bus.RVALID  = 1'b0;
        case (r_state)
            R_IDLE: begin
                bus.ARREADY = 1'b1;
                if (bus.ARVALID) r_next = R_DATA;
            end
            R_DATA: begin
                bus.RVALID = 1'b1;
                if (bus.RREADY && r_last_beat) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            rdata   <= '0;
`ifdef AXI_SLV_ERR_CHK_EN
            r_err   <= 1'b0;
`endif
        end else if (ar_hs) begin
            r_id    <= bus.ARID;
            r_addr  <= bus.ARADDR;
            r_len   <= bus.ARLEN;
            r_size  <= bus.ARSIZE;
            r_burst <= bus.ARBURST;
            r_cnt   <= '0;
            rdata   <= mem[bus.ARADDR[MEM_AW+1:2]];
`ifdef AXI_SLV_ERR_CHK_EN
            r_err   <= burst_err(bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST);
`endif
        end else if (r_adv) begin
            r_addr <= r_addr_nxt;
            r_cnt  <= r_cnt + 8'd1;
            rdata  <= mem[r_addr_nxt[MEM_AW+1:2]];
        end
    end

    assign bus.RID   = r_id;
    assign bus.RLAST = (r_state == R_DATA) && r_last_beat;

`ifdef AXI_SLV_ERR_CHK_EN
    assign bus.RDATA = r_err ? '0 : rdata;
    assign bus.RRESP = r_err ? 2'b10 : 2'b00;
    assign bus.BRESP = w_err ? 2'b10 : 2'b00;
`else
    assign bus.RDATA = rdata;
    assign bus.RRESP = 2'b00;
    assign bus.BRESP = 2'b00;
`endif
endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: a byte-lane memory model predicts every B and R beat.
`timescale 1ns/1ps
module tb_axi_slave_mem;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_slave_mem_if #(.AXI_ID_WD(2), .AXI_DATA_WD(32), .AXI_ADDR_WD(16), .AXI_STRB_WD(4)) bus ();

    axi_slave_mem #(
        .AXI_ID_WD(2), .AXI_DATA_WD(32), .AXI_ADDR_WD(16), .AXI_STRB_WD(4), .MEM_AW(10)
    ) dut (
        .AXI_ACLK   (clk),
        .AXI_ARESETN(rst_n),
        .bus        (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_mem [1024];
    logic [31:0] wbuf [256];
    logic [3:0]  sbuf [256];

    logic [31:0] exp_data_q [$];
    logic        exp_last_q [$];
    logic [1:0]  exp_resp_q [$];
    logic [1:0]  exp_b_q    [$];

    // Beat address derived as base + offset within the burst, wrapped inside the container for WRAP.
    function automatic logic [15:0] beat_addr(input logic [15:0] base, input int i,
                                              input int len, input logic [1:0] burst);
        int cont, off;
        case (burst)
            2'b00: return base;
            2'b10: begin
                cont = (len + 1) * 4;
                off  = int'(base) % cont;
                return 16'(int'(base) - off + ((off + 4 * i) % cont));
            end
            default: return 16'(int'(base) + 4 * i);
        endcase
    endfunction

    task automatic axi_write(input logic [1:0] id, input logic [15:0] addr, input int len,
                             input logic [1:0] burst, input logic err);
        int n;
        logic [15:0] a;
        logic [1:0] eb;
        exp_b_q.push_back(err ? 2'b10 : 2'b00);
        @(negedge clk);
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = 8'(len);
        bus.AWSIZE = 3'd2; bus.AWBURST = burst; bus.AWVALID = 1'b1;
        n = 0;
        while (!bus.AWREADY && n < 50) begin @(negedge clk); n++; end
        n_cmp++;
        if (!bus.AWREADY) begin n_bad++; $display("FAIL aw_timeout awready=%b want 1", bus.AWREADY); end
        @(negedge clk);
        bus.AWVALID = 1'b0;
        n_cmp++;
        if (bus.WREADY !== 1'b1) begin n_bad++; $display("FAIL w_latency wready=%b want 1", bus.WREADY); end
        for (int i = 0; i <= len; i++) begin
            bus.WDATA = wbuf[i]; bus.WSTRB = sbuf[i]; bus.WLAST = (i == len); bus.WVALID = 1'b1;
            n = 0;
            while (!bus.WREADY && n < 50) begin @(negedge clk); n++; end
            if (!err) begin
                a = beat_addr(addr, i, len, burst);
                for (int b = 0; b < 4; b++)
                    if (sbuf[i][b]) model_mem[a[11:2]][b*8 +: 8] = wbuf[i][b*8 +: 8];
            end
            @(negedge clk);
        end
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        n_cmp++;
        if (bus.BVALID !== 1'b1) begin n_bad++; $display("FAIL b_latency bvalid=%b want 1", bus.BVALID); end
        bus.BREADY = 1'b1;
        n = 0;
        while (!bus.BVALID && n < 50) begin @(negedge clk); n++; end
        eb = exp_b_q.pop_front();
        n_cmp++;
        if (bus.BRESP !== eb) begin n_bad++; $display("FAIL bresp got=%0d want=%0d", bus.BRESP, eb); end
        n_cmp++;
        if (bus.BID !== id) begin n_bad++; $display("FAIL bid got=%0d want=%0d", bus.BID, id); end
        @(negedge clk);
        bus.BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [1:0] id, input logic [15:0] addr, input int len,
                            input logic [1:0] burst, input logic toggle, input logic err);
        int n, got, cyc;
        logic held_v, held_l;
        logic [31:0] held_d, ed;
        logic el;
        logic [1:0] er;
        logic [15:0] a;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, i, len, burst);
            exp_data_q.push_back(err ? 32'h0 : model_mem[a[11:2]]);
            exp_last_q.push_back(i == len);
            exp_resp_q.push_back(err ? 2'b10 : 2'b00);
        end
        @(negedge clk);
        bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = 8'(len);
        bus.ARSIZE = 3'd2; bus.ARBURST = burst; bus.ARVALID = 1'b1;
        n = 0;
        while (!bus.ARREADY && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.ARVALID = 1'b0;
        n_cmp++;
        if (bus.RVALID !== 1'b1) begin n_bad++; $display("FAIL r_latency rvalid=%b want 1", bus.RVALID); end
        got = 0; cyc = 0; held_v = 1'b0; held_d = '0; held_l = 1'b0;
        while (got <= len && cyc < 1000) begin
            if (held_v) begin
                n_cmp++;
                if (bus.RDATA !== held_d || bus.RLAST !== held_l) begin
                    n_bad++;
                    $display("FAIL r_stall_hold data=%h last=%b want data=%h last=%b",
                             bus.RDATA, bus.RLAST, held_d, held_l);
                end
                held_v = 1'b0;
            end
            bus.RREADY = toggle ? ((cyc % 2) == 1) : 1'b1;
            if (bus.RVALID) begin
                if (bus.RREADY) begin
                    ed = exp_data_q.pop_front(); el = exp_last_q.pop_front(); er = exp_resp_q.pop_front();
                    n_cmp++;
                    if (bus.RDATA !== ed) begin n_bad++; $display("FAIL rdata beat %0d got=%h want=%h", got, bus.RDATA, ed); end
                    n_cmp++;
                    if (bus.RLAST !== el) begin n_bad++; $display("FAIL rlast beat %0d got=%b want=%b", got, bus.RLAST, el); end
                    n_cmp++;
                    if (bus.RRESP !== er) begin n_bad++; $display("FAIL rresp beat %0d got=%0d want=%0d", got, bus.RRESP, er); end
                    n_cmp++;
                    if (bus.RID !== id) begin n_bad++; $display("FAIL rid got=%0d want=%0d", bus.RID, id); end
                    got++;
                end else begin
                    held_v = 1'b1; held_d = bus.RDATA; held_l = bus.RLAST;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.RREADY = 1'b0;
        n_cmp++;
        if (got <= len) begin n_bad++; $display("FAIL r_timeout beats=%0d want=%0d", got, len + 1); end
        n_cmp++;
        if (bus.RVALID !== 1'b0) begin n_bad++; $display("FAIL r_done rvalid=%b want 0", bus.RVALID); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (bus.AWREADY !== 1'b1) begin n_bad++; $display("FAIL rst_awready got=%b want 1", bus.AWREADY); end
        n_cmp++; if (bus.ARREADY !== 1'b1) begin n_bad++; $display("FAIL rst_arready got=%b want 1", bus.ARREADY); end
        n_cmp++; if (bus.WREADY  !== 1'b0) begin n_bad++; $display("FAIL rst_wready got=%b want 0", bus.WREADY); end
        n_cmp++; if (bus.BVALID  !== 1'b0) begin n_bad++; $display("FAIL rst_bvalid got=%b want 0", bus.BVALID); end
        n_cmp++; if (bus.RVALID  !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid got=%b want 0", bus.RVALID); end
        n_cmp++; if (bus.RLAST   !== 1'b0) begin n_bad++; $display("FAIL rst_rlast got=%b want 0", bus.RLAST); end
        n_cmp++; if (bus.RDATA   !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got=%h want 0", bus.RDATA); end
        n_cmp++; if ({bus.BRESP, bus.RRESP, bus.BID, bus.RID} !== 8'h0) begin
            n_bad++; $display("FAIL rst_resp_id got=%h want 0", {bus.BRESP, bus.RRESP, bus.BID, bus.RID});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        wbuf[0] = 32'hA5A5_1234; sbuf[0] = 4'hF;
        axi_write(2'd0, 16'h0010, 0, INCR, 1'b0);
        axi_read(2'd0, 16'h0010, 0, INCR, 1'b0, 1'b0);
    endtask

    task automatic test_incr();
        for (int i = 0; i < 16; i++) begin wbuf[i] = 32'(i); sbuf[i] = 4'hF; end
        axi_write(2'd1, 16'h00FC, 15, INCR, 1'b0);
        axi_read(2'd1, 16'h00FC, 15, INCR, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hC0DE_0000 + 32'(i); sbuf[i] = 4'hF; end
        axi_write(2'd2, 16'h0108, 3, WRAP, 1'b0);
        axi_read(2'd2, 16'h0100, 3, INCR, 1'b0, 1'b0);
        axi_read(2'd3, 16'h0108, 3, WRAP, 1'b1, 1'b0);
    endtask

    task automatic test_fixed();
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h0F00_0010 + 32'(i); sbuf[i] = 4'hF; end
        axi_write(2'd1, 16'h0200, 3, FIXED, 1'b0);
        axi_read(2'd1, 16'h0200, 0, INCR, 1'b0, 1'b0);
        axi_read(2'd2, 16'h0200, 2, FIXED, 1'b0, 1'b0);
    endtask

    task automatic test_strobe();
        wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'hF;
        axi_write(2'd0, 16'h0040, 0, INCR, 1'b0);
        wbuf[0] = 32'h1122_3344; sbuf[0] = 4'h5;
        axi_write(2'd0, 16'h0040, 0, INCR, 1'b0);
        axi_read(2'd0, 16'h0040, 0, INCR, 1'b0, 1'b0);
        axi_read(2'd1, 16'h1040, 0, INCR, 1'b0, 1'b0);
    endtask

    task automatic test_4k_cross();
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h5500_0000 + 32'(i); sbuf[i] = 4'hF; end
        axi_write(2'd0, 16'h0FF8, 1, INCR, 1'b0);
        for (int i = 0; i < 2; i++) wbuf[i] = 32'h6600_0000 + 32'(i);
        axi_write(2'd0, 16'h1000, 1, INCR, 1'b0);
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h7700_0000 + 32'(i);
`ifdef AXI_SLV_ERR_CHK_EN
        axi_write(2'd3, 16'h0FF8, 3, INCR, 1'b1);
        axi_read(2'd0, 16'h0FF8, 1, INCR, 1'b0, 1'b0);
        axi_read(2'd0, 16'h1000, 1, INCR, 1'b0, 1'b0);
        axi_read(2'd3, 16'h0FF8, 3, INCR, 1'b0, 1'b1);
`else
        axi_write(2'd3, 16'h0FF8, 3, INCR, 1'b0);
        axi_read(2'd3, 16'h0FF8, 3, INCR, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_reset_mid();
        int n, got;
        logic [15:0] a;
        for (int i = 0; i < 8; i++) begin wbuf[i] = 32'hBEEF_0000 + 32'(i * 3); sbuf[i] = 4'hF; end
        axi_write(2'd2, 16'h0300, 7, INCR, 1'b0);
        @(negedge clk);
        bus.ARID = 2'd2; bus.ARADDR = 16'h0300; bus.ARLEN = 8'd7;
        bus.ARSIZE = 3'd2; bus.ARBURST = INCR; bus.ARVALID = 1'b1;
        @(negedge clk);
        bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
        got = 0; n = 0;
        while (got < 2 && n < 50) begin
            if (bus.RVALID) begin
                a = beat_addr(16'h0300, got, 7, INCR);
                n_cmp++;
                if (bus.RDATA !== model_mem[a[11:2]]) begin
                    n_bad++; $display("FAIL rst_mid_rdata beat %0d got=%h want=%h", got, bus.RDATA, model_mem[a[11:2]]);
                end
                got++;
            end
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.RVALID !== 1'b0) begin n_bad++; $display("FAIL rst_mid_rvalid got=%b want 0", bus.RVALID); end
        n_cmp++; if (bus.ARREADY !== 1'b1) begin n_bad++; $display("FAIL rst_mid_arready got=%b want 1", bus.ARREADY); end
        n_cmp++; if (bus.RLAST !== 1'b0) begin n_bad++; $display("FAIL rst_mid_rlast got=%b want 0", bus.RLAST); end
        bus.RREADY = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        axi_read(2'd1, 16'h0300, 7, INCR, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h0BB0_0000 + 32'(i << 8); sbuf[i] = 4'hF; end
        axi_write(2'd3, 16'h03F0, 3, INCR, 1'b0);
        axi_read(2'd2, 16'h03F8, 1, INCR, 1'b0, 1'b0);
        axi_read(2'd3, 16'h03F0, 3, WRAP, 1'b1, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_incr();
        test_wrap();
        test_fixed();
        test_strobe();
        test_4k_cross();
        test_reset_mid();
        test_back_to_back();
        n_cmp++;
        if (exp_data_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_data_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
